// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and baud-divider derivation.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_t;

    function automatic int bit_cnt(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int half_cnt(input int clk_hz, input int baud);
        return bit_cnt(clk_hz, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Free-running clock counter with synchronous clear/load and an equality terminal flag.
module uart_baud_cnt #(
    parameter int W = 16
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] term_val,
    output logic         term
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign term = (cnt == term_val);

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 serial receiver: two-flop input sync, mid-bit sampling FSM, registered byte/flag outputs.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       uRx,
    output logic [7:0] rx_data,
    output logic       rx_int,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int BIT_CNT  = bit_cnt(CLK_HZ, BAUD);
    localparam int HALF_CNT = half_cnt(CLK_HZ, BAUD);
    localparam logic [15:0] BIT_TERM  = 16'(BIT_CNT - 1);
    localparam logic [15:0] HALF_TERM = 16'(HALF_CNT - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

    if (BIT_CNT < 4 || BIT_CNT > 65536) begin : g_bad_baud
        $error("uart_rx_frame: BIT_CNT out of range for a 16-bit baud counter");
    end

    logic        rx_meta, rx_s, rx_s_d;
    logic        start_edge;
    uart_state_t state;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        term, cnt_clr;
    logic [15:0] term_val;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= uRx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    assign start_edge = rx_s_d & ~rx_s;

    // Counter is held at zero while waiting for the line, so it restarts on every state change.
    assign cnt_clr  = (state == IDLE) || (state == WAIT_IDLE) || term;
    assign term_val = (state == START) ? HALF_TERM : BIT_TERM;

    uart_baud_cnt #(.W(16)) u_baud (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (1'b0),
        .load_val (16'd0),
        .term_val (term_val),
        .term     (term)
    );

    always_ff @(posedge clk_in) begin
        if (state == DATA && term) begin
            shift <= {rx_s, shift[7:1]};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_idx   <= '0;
            rx_data   <= 8'h00;
            rx_int    <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state  <= START;
                        rx_int <= 1'b1;
                    end
                end
                START: begin
                    if (term) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state  <= IDLE;
                            rx_int <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (term) begin
                        if (bit_idx == LAST_BIT) state <= STOP;
                        else                     bit_idx <= bit_idx + 1'b1;
                    end
                end
                STOP: begin
                    if (term) begin
                        if (rx_s) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            rx_int   <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    // A held-low line (break) must return high before a new start is armed.
                    if (rx_s) begin
                        rx_int <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    rx_int <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at BIT_CNT=16 with a byte scoreboard and timing checks.
module tb_uart_rx_frame;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic       uRx    = 1'b1;
    logic [7:0] rx_data;
    logic       rx_int, rx_valid, frame_err;

    uart_rx_frame #(.CLK_HZ(16), .BAUD(1)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .uRx       (uRx),
        .rx_data   (rx_data),
        .rx_int    (rx_int),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    int valid_cnt = 0, ferr_cnt = 0, rise_cnt = 0;
    int last_valid_cyc = -1, prev_valid_cyc = -1;
    int rise_cyc = -1, fall_cyc = -1, ferr_cyc = -1;
    logic prev_int = 1'b0, prev_vld = 1'b0, prev_ferr = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(posedge clk_in) cyc++;

    // Output monitor: scoreboard pop on rx_valid, pulse-shape and edge-time bookkeeping.
    always @(negedge clk_in) begin
        if (rst_n) begin
            if (rx_valid) begin
                valid_cnt++;
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_rx_valid", 32'd1, 32'd0);
                end else begin
                    check("rx_data_scoreboard", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
                check("valid_ferr_exclusive", {31'd0, frame_err}, 32'd0);
                check("rx_valid_width", {31'd0, prev_vld}, 32'd0);
            end
            if (frame_err) begin
                ferr_cnt++;
                ferr_cyc = cyc;
                check("frame_err_width", {31'd0, prev_ferr}, 32'd0);
            end
        end
        if (rx_int && !prev_int) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        if (!rx_int && prev_int) fall_cyc = cyc;
        prev_int  = rx_int;
        prev_vld  = rx_valid;
        prev_ferr = frame_err;
    end

    // Called at a negedge; drives start, 8 data bits LSB-first, optional low stop, then 16 idle.
    task automatic send_frame(input logic [7:0] b, input int stop_low, output int p);
        p   = cyc;
        uRx = 1'b0;
        repeat (16) @(negedge clk_in);
        for (int k = 0; k < 8; k++) begin
            uRx = b[k];
            repeat (16) @(negedge clk_in);
        end
        if (stop_low > 0) begin
            uRx = 1'b0;
            repeat (stop_low) @(negedge clk_in);
        end
        uRx = 1'b1;
        repeat (16) @(negedge clk_in);
    endtask

    initial begin
        int p, p2, v0, f0, r0;
        logic [7:0] partial;

        repeat (3) @(negedge clk_in);
        check("reset_rx_data", {24'd0, rx_data}, 32'h00);
        check("reset_rx_int", {31'd0, rx_int}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;

        repeat (200) @(negedge clk_in);
        check("idle_valid_cnt", valid_cnt, 0);
        check("idle_rise_cnt", rise_cnt, 0);
        check("idle_rx_data", {24'd0, rx_data}, 32'h00);

        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 0, p);
        check("a5_valid_cnt", valid_cnt, 1);
        check("a5_rx_data", {24'd0, rx_data}, 32'hA5);
        check("a5_valid_time", last_valid_cyc, p + 155);
        check("a5_int_rise", rise_cyc, p + 3);
        check("a5_int_fall", fall_cyc, p + 155);
        check("a5_frame_err", ferr_cnt, 0);

        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hFF);
        send_frame(8'h3C, 0, p);
        send_frame(8'hFF, 0, p2);
        check("b2b_valid_cnt", valid_cnt, 3);
        check("b2b_spacing", last_valid_cyc - prev_valid_cyc, 160);
        check("b2b_second_time", last_valid_cyc, p2 + 155);
        check("b2b_rx_data", {24'd0, rx_data}, 32'hFF);

        v0 = valid_cnt; f0 = ferr_cnt; r0 = rise_cnt;
        p = cyc;
        uRx = 1'b0;
        repeat (4) @(negedge clk_in);
        uRx = 1'b1;
        repeat (40) @(negedge clk_in);
        check("glitch_int_rose", rise_cnt - r0, 1);
        check("glitch_int_fall", fall_cyc, p + 11);
        check("glitch_rx_int", {31'd0, rx_int}, 32'd0);
        check("glitch_no_valid", valid_cnt - v0, 0);
        check("glitch_no_ferr", ferr_cnt - f0, 0);
        check("glitch_rx_data", {24'd0, rx_data}, 32'hFF);

        v0 = valid_cnt;
        send_frame(8'h55, 40, p);
        check("ferr_count", ferr_cnt, 1);
        check("ferr_time", ferr_cyc, p + 155);
        check("ferr_no_valid", valid_cnt - v0, 0);
        check("ferr_rx_data_kept", {24'd0, rx_data}, 32'hFF);
        check("ferr_int_fall", fall_cyc, p + 187);
        check("ferr_rx_int_low", {31'd0, rx_int}, 32'd0);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 0, p);
        check("after_ferr_rx_data", {24'd0, rx_data}, 32'h12);
        check("after_ferr_time", last_valid_cyc, p + 155);

        v0 = valid_cnt; f0 = ferr_cnt;
        partial = 8'hC3;
        uRx = 1'b0;
        repeat (16) @(negedge clk_in);
        for (int k = 0; k < 4; k++) begin
            uRx = partial[k];
            repeat (16) @(negedge clk_in);
        end
        uRx = partial[4];
        repeat (8) @(negedge clk_in);
        check("pre_reset_rx_int", {31'd0, rx_int}, 32'd1);
        check("pre_reset_rx_data", {24'd0, rx_data}, 32'h12);
        rst_n = 1'b0;
        uRx   = 1'b1;
        #1;
        check("async_reset_rx_int", {31'd0, rx_int}, 32'd0);
        check("async_reset_rx_data", {24'd0, rx_data}, 32'h00);
        check("async_reset_valid", {31'd0, rx_valid}, 32'd0);
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (40) @(negedge clk_in);
        check("reset_no_valid", valid_cnt - v0, 0);
        check("reset_no_ferr", ferr_cnt - f0, 0);
        check("reset_rx_int_idle", {31'd0, rx_int}, 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 0, p);
        check("post_reset_rx_data", {24'd0, rx_data}, 32'h81);
        check("post_reset_time", last_valid_cyc, p + 155);

        repeat (20) @(negedge clk_in);
        check("total_valid", valid_cnt, 5);
        check("total_ferr", ferr_cnt, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
